// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory with combinational fetch and a tagged serial program-load port
module instr_mem_loader #(
  parameter int WORD_LEN = 32,
  parameter int DEPTH = 256,
  parameter logic [7:0] START_TAG = 8'hFE,
  parameter logic [7:0] END_TAG = 8'hFF,
  parameter logic [WORD_LEN-1:0] NOP_WORD = '0,
  parameter bit CLEAR_ON_RST = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                i_CLK,
  input  logic                i_RSTN,
  input  logic                i_Load_Valid,
  input  logic [WORD_LEN-1:0] i_Load_Data,
  output logic                o_Load_Ready,
  input  logic [WORD_LEN-1:0] i_Addr,
  output logic [WORD_LEN-1:0] o_Instr,
  output logic                o_Misalign,
  output logic                o_Out_Range,
  output logic                o_Busy,
  output logic                o_Load_Done,
  output logic                o_Load_Err,
  output logic [AW:0]         o_Load_Count
);
  typedef enum logic [1:0] {IDLE, LOAD, ERR} state_t;
  state_t state_q, state_d;
  logic [AW:0] ptr_q, ptr_d, cnt_q, cnt_d;
  logic err_q, err_d, done_q, done_d, wr_en;
  logic [WORD_LEN-1:0] mem_q [DEPTH];
  logic [7:0] tag;
  logic is_start, is_end, is_pay;
  logic [AW:0] base;
  assign tag = i_Load_Data[WORD_LEN-1 -: 8];
  assign is_start = i_Load_Valid && tag == START_TAG;
  assign is_end = i_Load_Valid && tag == END_TAG;
  assign is_pay = i_Load_Valid && !is_start && !is_end;
  assign base = {1'b0, i_Load_Data[AW-1:0]};
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    done_d = 1'b0;
    wr_en = 1'b0;
    case (state_q)
      IDLE: if (is_start) begin
        state_d = LOAD;
        ptr_d = base;
        cnt_d = '0;
        err_d = 1'b0;
      end
      LOAD: if (is_start) begin
        ptr_d = base;
        cnt_d = '0;
      end else if (is_end) begin
        state_d = IDLE;
        done_d = 1'b1;
      end else if (is_pay && ptr_q[AW]) begin
        // ptr only ever reaches DEPTH, never beyond, so the top bit marks a full memory
        state_d = ERR;
        err_d = 1'b1;
      end else if (is_pay) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
      ERR: if (is_end) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      if (CLEAR_ON_RST)
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[ptr_q[AW-1:0]] <= i_Load_Data;
    end
  end
  assign o_Load_Ready = 1'b1;
  assign o_Misalign = |i_Addr[1:0];
  assign o_Out_Range = |i_Addr[WORD_LEN-1:AW+2];
  assign o_Instr = o_Out_Range ? NOP_WORD : mem_q[i_Addr[AW+1:2]];
  assign o_Busy = state_q != IDLE;
  assign o_Load_Done = done_q;
  assign o_Load_Err = err_q;
  assign o_Load_Count = cnt_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed checks of load stream, overflow, fetch range and reset behaviour
module tb_instr_mem_loader;
  logic clk = 1'b0, rstn = 1'b0, valid = 1'b0;
  logic [31:0] ldata = '0, addr = '0, instr;
  logic ready, misalign, out_range, busy, done, err;
  logic [8:0] count;
  int n_cmp = 0, n_bad = 0;

  instr_mem_loader dut (
    .i_CLK(clk), .i_RSTN(rstn), .i_Load_Valid(valid), .i_Load_Data(ldata),
    .o_Load_Ready(ready), .i_Addr(addr), .o_Instr(instr), .o_Misalign(misalign),
    .o_Out_Range(out_range), .o_Busy(busy), .o_Load_Done(done), .o_Load_Err(err),
    .o_Load_Count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    valid = 1'b1;
    ldata = w;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(tag, instr, exp);
  endtask

  initial begin
    idle(2);
    rstn = 1'b1;
    // T1: preload, reset, expect cleared state
    send(32'hFE000000); send(32'hAAAA0001); send(32'hAAAA0002); send(32'hFF000000);
    fetch("t1_preload", 32'h0, 32'hAAAA0001);
    reset_pulse();
    fetch("t1_mem0", 32'h0, 32'h0);
    fetch("t1_mem1", 32'h4, 32'h0);
    check("t1_busy", {31'b0, busy}, 32'h0);
    check("t1_err", {31'b0, err}, 32'h0);
    check("t1_count", {23'b0, count}, 32'h0);
    check("t1_ready", {31'b0, ready}, 32'h1);
    // T2: basic load from base 0
    send(32'hFE000000);
    check("t2_busy_start", {31'b0, busy}, 32'h1);
    send(32'h00000013); send(32'h00500093);
    check("t2_count_mid", {23'b0, count}, 32'h2);
    check("t2_done_early", {31'b0, done}, 32'h0);
    send(32'hFF000000);
    check("t2_done", {31'b0, done}, 32'h1);
    check("t2_busy_end", {31'b0, busy}, 32'h0);
    idle(1);
    check("t2_done_pulse", {31'b0, done}, 32'h0);
    check("t2_count", {23'b0, count}, 32'h2);
    fetch("t2_mem0", 32'h0, 32'h00000013);
    fetch("t2_mem1", 32'h4, 32'h00500093);
    // T3: base address load
    send(32'hFE000010); send(32'h11111111); send(32'hFF000000);
    check("t3_count", {23'b0, count}, 32'h1);
    fetch("t3_mem16", 32'h40, 32'h11111111);
    fetch("t3_mem0", 32'h0, 32'h00000013);
    fetch("t3_mem15", 32'h3C, 32'h0);
    // restart inside LOAD; tag words are never stored
    send(32'hFE000020); send(32'h33333333); send(32'hFE000030); send(32'h44444444);
    send(32'hFF000000);
    check("rs_count", {23'b0, count}, 32'h1);
    fetch("rs_mem32", 32'h80, 32'h33333333);
    fetch("rs_mem48", 32'hC0, 32'h44444444);
    fetch("rs_mem49", 32'hC4, 32'h0);
    // T4: overflow at top of memory
    send(32'hFE0000FE); send(32'h22222201); send(32'h22222202);
    check("t4_err_before", {31'b0, err}, 32'h0);
    send(32'h22222203);
    check("t4_err", {31'b0, err}, 32'h1);
    check("t4_busy_err", {31'b0, busy}, 32'h1);
    send(32'hFE000000);
    check("t4_err_start_ignored", {31'b0, err}, 32'h1);
    send(32'hFF000000);
    check("t4_done", {31'b0, done}, 32'h1);
    check("t4_busy_end", {31'b0, busy}, 32'h0);
    check("t4_err_sticky", {31'b0, err}, 32'h1);
    check("t4_count", {23'b0, count}, 32'h2);
    fetch("t4_mem254", 32'h3F8, 32'h22222201);
    fetch("t4_mem255", 32'h3FC, 32'h22222202);
    fetch("t4_mem0", 32'h0, 32'h00000013);
    send(32'hFE000100);
    check("t4_err_clear", {31'b0, err}, 32'h0);
    send(32'hFF000000);
    // T5: fetch range and alignment
    fetch("t5_nop", 32'h402, 32'h0);
    check("t5_mis", {31'b0, misalign}, 32'h1);
    check("t5_oor", {31'b0, out_range}, 32'h1);
    fetch("t5_oor_aligned", 32'h400, 32'h0);
    check("t5_mis0", {31'b0, misalign}, 32'h0);
    fetch("t5_top", 32'h3FC, 32'h22222202);
    check("t5_oor0", {31'b0, out_range}, 32'h0);
    fetch("t5_lowbits", 32'h3FE, 32'h22222202);
    check("t5_mis_top", {31'b0, misalign}, 32'h1);
    fetch("t5_far", 32'h80000000, 32'h0);
    // T6: gaps between payloads
    send(32'hFE000040); send(32'h55555555);
    ldata = 32'h66666666;
    idle(3);
    send(32'h77777777); send(32'hFF000000);
    check("t6_count", {23'b0, count}, 32'h2);
    fetch("t6_mem64", 32'h100, 32'h55555555);
    fetch("t6_mem65", 32'h104, 32'h77777777);
    fetch("t6_mem66", 32'h108, 32'h0);
    // END in IDLE is ignored
    send(32'hFF000000);
    check("idle_end_done", {31'b0, done}, 32'h0);
    // reset mid-load with a payload on the reset edge
    send(32'hFE000050); send(32'h88888888);
    rstn = 1'b0; valid = 1'b1; ldata = 32'h99999999;
    @(posedge clk);
    #1 rstn = 1'b1; valid = 1'b0;
    check("t6_rst_busy", {31'b0, busy}, 32'h0);
    check("t6_rst_count", {23'b0, count}, 32'h0);
    send(32'hAAAAAAAA);
    check("t6_idle_pay_busy", {31'b0, busy}, 32'h0);
    fetch("t6_mem80", 32'h140, 32'h0);
    fetch("t6_mem81", 32'h144, 32'h0);
    fetch("t6_mem0_cleared", 32'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
